// File: rtl/nvdla_dbb_pkg.sv
// Shared widths, AXI sideband constants and the outstanding-count update rule for the DBB limiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nvdla_dbb_pkg;

    localparam int UP_ID_W  = 8;
    localparam int DN_ID_W  = 6;
    localparam int UP_LEN_W = 4;
    localparam int DN_LEN_W = 8;
    localparam int OSTD_W   = 8;

    typedef logic [OSTD_W-1:0] ostd_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Fixed AXI sideband driven toward the interconnect
    localparam logic [2:0] AXI_SIZE   = 3'b011;
    localparam logic [1:0] AXI_BURST  = 2'b01;   // INCR
    localparam logic       AXI_LOCK   = 1'b0;
    localparam logic [3:0] AXI_CACHE  = 4'b0010;
    localparam logic [2:0] AXI_PROT   = 3'b000;
    localparam logic [3:0] AXI_QOS    = 4'b0000;
    localparam logic       AXI_AUSER  = 1'b1;
    localparam logic       AXI_WUSER  = 1'b0;

    // Next outstanding count. A decrement at zero is dropped (the caller flags
    // underflow); if a new burst is accepted in that same cycle it still counts.
    function automatic ostd_t ostd_next(input ostd_t cnt, input logic inc, input logic dec);
        ostd_t nxt;
        nxt = cnt;
        if (inc && !dec)
            nxt = cnt + ostd_t'(1);
        else if (!inc && dec && cnt != '0)
            nxt = cnt - ostd_t'(1);
        else if (inc && dec && cnt == '0)
            nxt = cnt + ostd_t'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/nvdla_dbb_ostd_limiter_if.sv
// One AXI port (AR/AW/W/B/R) with parameterised ID/len widths; master drives requests, slave drives responses.
// Latency: n/a (wires only).
// Backpressure: plain valid/ready on every channel.
interface nvdla_dbb_ostd_limiter_if #(
    parameter int ID_W  = 8,
    parameter int LEN_W = 4,
    parameter int AW    = 32,
    parameter int DW    = 64
);
    logic             ar_valid, ar_ready, ar_lock, ar_user;
    logic [ID_W-1:0]  ar_id;
    logic [LEN_W-1:0] ar_len;
    logic [AW-1:0]    ar_addr;
    logic [2:0]       ar_size, ar_prot;
    logic [1:0]       ar_burst;
    logic [3:0]       ar_cache, ar_qos;

    logic             aw_valid, aw_ready, aw_lock, aw_user;
    logic [ID_W-1:0]  aw_id;
    logic [LEN_W-1:0] aw_len;
    logic [AW-1:0]    aw_addr;
    logic [2:0]       aw_size, aw_prot;
    logic [1:0]       aw_burst;
    logic [3:0]       aw_cache, aw_qos;

    logic             w_valid, w_ready, w_last, w_user;
    logic [DW-1:0]    w_data;
    logic [DW/8-1:0]  w_strb;

    logic             b_valid, b_ready;
    logic [ID_W-1:0]  b_id;
    logic [1:0]       b_resp;

    logic             r_valid, r_ready, r_last;
    logic [ID_W-1:0]  r_id;
    logic [DW-1:0]    r_data;
    logic [1:0]       r_resp;

    modport master (
        output ar_valid, ar_id, ar_len, ar_addr, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_user,
        output aw_valid, aw_id, aw_len, aw_addr, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_user,
        output w_valid, w_data, w_strb, w_last, w_user, b_ready, r_ready,
        input  ar_ready, aw_ready, w_ready,
        input  b_valid, b_id, b_resp, r_valid, r_id, r_data, r_resp, r_last
    );

    modport slave (
        input  ar_valid, ar_id, ar_len, ar_addr, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_user,
        input  aw_valid, aw_id, aw_len, aw_addr, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_user,
        input  w_valid, w_data, w_strb, w_last, w_user, b_ready, r_ready,
        output ar_ready, aw_ready, w_ready,
        output b_valid, b_id, b_resp, r_valid, r_id, r_data, r_resp, r_last
    );
endinterface

// File: rtl/nvdla_dbb_addr_slice.sv
// 1-entry forward register slice for an AR/AW address channel, narrowing ID 8b->6b and widening len 4b->8b.
// Latency: 1 cycle, full throughput (refills in the same cycle it drains).
// Backpressure: o_up_rdy = (empty || i_dn_rdy) && i_allow; payload frozen while o_dn_vld && !i_dn_rdy.
// Ports: i_clk/i_rst, upstream vld/rdy+id/len/addr, downstream vld/rdy+id/len/addr,
//        i_allow (outstanding gate), o_acc (upstream handshake), o_id_trunc (accepted ID had bits above DN_ID_W).
module nvdla_dbb_addr_slice
    import nvdla_dbb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_allow,
    input  logic                i_up_vld,
    output logic                o_up_rdy,
    input  logic [UP_ID_W-1:0]  i_up_id,
    input  logic [UP_LEN_W-1:0] i_up_len,
    input  logic [AW-1:0]       i_up_addr,
    output logic                o_dn_vld,
    input  logic                i_dn_rdy,
    output logic [DN_ID_W-1:0]  o_dn_id,
    output logic [DN_LEN_W-1:0] o_dn_len,
    output logic [AW-1:0]       o_dn_addr,
    output logic                o_acc,
    output logic                o_id_trunc
);
    logic                r_vld;
    logic [DN_ID_W-1:0]  r_id;
    logic [DN_LEN_W-1:0] r_len;
    logic [AW-1:0]       r_addr;
    logic                w_load;
    logic                w_acc;

    assign w_load     = !r_vld || i_dn_rdy;
    assign o_up_rdy   = w_load && i_allow;
    assign w_acc      = i_up_vld && o_up_rdy;
    assign o_acc      = w_acc;
    assign o_id_trunc = w_acc && (i_up_id[UP_ID_W-1:DN_ID_W] != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_id   <= '0;
            r_len  <= '0;
            r_addr <= '0;
        end else if (w_load) begin
            r_vld <= w_acc;
            if (w_acc) begin
                r_id   <= i_up_id[DN_ID_W-1:0];
                r_len  <= {{(DN_LEN_W-UP_LEN_W){1'b0}}, i_up_len};
                r_addr <= i_up_addr;
            end
        end
    end

    assign o_dn_vld  = r_vld;
    assign o_dn_id   = r_id;
    assign o_dn_len  = r_len;
    assign o_dn_addr = r_addr;
endmodule

// File: rtl/nvdla_dbb_ostd_limiter.sv
// Registers AR/AW toward the SoC bus, adapts ID/len widths, caps outstanding reads/writes, flags faults.
// Latency: AR/AW 1 cycle; W/B/R combinational pass-through.
// Backpressure: up AR/AW ready drops when the slice is blocked or the outstanding count is at its cap.
// Ports: dla_core_clk, dla_reset (sync, active-high); up = core-side slave port, dn = bus-side master port;
//        rd_ostd/wr_ostd counts; sts_id_trunc/sts_underflow sticky flags; rresp/bresp_err_cnt.
// Option NVDLA_DBB_RESP_ERR_CNT_EN: enables the saturating error-response counters (tied to 0 otherwise).
module nvdla_dbb_ostd_limiter
    import nvdla_dbb_pkg::*;
#(
    parameter int MAX_RD_OSTD = 8,
    parameter int MAX_WR_OSTD = 8,
    parameter int AW          = 32,
    parameter int DW          = 64
) (
    input  logic                     dla_core_clk,
    input  logic                     dla_reset,
    nvdla_dbb_ostd_limiter_if.slave  up,
    nvdla_dbb_ostd_limiter_if.master dn,
    output logic [OSTD_W-1:0]        rd_ostd,
    output logic [OSTD_W-1:0]        wr_ostd,
    output logic                     sts_id_trunc,
    output logic                     sts_underflow,
    output logic [15:0]              rresp_err_cnt,
    output logic [15:0]              bresp_err_cnt
);
    ostd_t r_rd_ostd, r_wr_ostd;
    logic  r_sts_id_trunc, r_sts_underflow;
    logic  w_ar_acc, w_aw_acc, w_ar_trunc, w_aw_trunc, w_rd_dec, w_wr_dec;
    logic  w_unused_ok;

    nvdla_dbb_addr_slice #(.AW(AW)) u_ar_slice (
        .i_clk(dla_core_clk), .i_rst(dla_reset), .i_allow(r_rd_ostd < ostd_t'(MAX_RD_OSTD)),
        .i_up_vld(up.ar_valid), .o_up_rdy(up.ar_ready),
        .i_up_id(up.ar_id), .i_up_len(up.ar_len), .i_up_addr(up.ar_addr),
        .o_dn_vld(dn.ar_valid), .i_dn_rdy(dn.ar_ready),
        .o_dn_id(dn.ar_id), .o_dn_len(dn.ar_len), .o_dn_addr(dn.ar_addr),
        .o_acc(w_ar_acc), .o_id_trunc(w_ar_trunc)
    );

    nvdla_dbb_addr_slice #(.AW(AW)) u_aw_slice (
        .i_clk(dla_core_clk), .i_rst(dla_reset), .i_allow(r_wr_ostd < ostd_t'(MAX_WR_OSTD)),
        .i_up_vld(up.aw_valid), .o_up_rdy(up.aw_ready),
        .i_up_id(up.aw_id), .i_up_len(up.aw_len), .i_up_addr(up.aw_addr),
        .o_dn_vld(dn.aw_valid), .i_dn_rdy(dn.aw_ready),
        .o_dn_id(dn.aw_id), .o_dn_len(dn.aw_len), .o_dn_addr(dn.aw_addr),
        .o_acc(w_aw_acc), .o_id_trunc(w_aw_trunc)
    );

    assign {dn.ar_size, dn.ar_burst, dn.ar_lock, dn.ar_cache, dn.ar_prot, dn.ar_qos, dn.ar_user} =
           {AXI_SIZE, AXI_BURST, AXI_LOCK, AXI_CACHE, AXI_PROT, AXI_QOS, AXI_AUSER};
    assign {dn.aw_size, dn.aw_burst, dn.aw_lock, dn.aw_cache, dn.aw_prot, dn.aw_qos, dn.aw_user} =
           {AXI_SIZE, AXI_BURST, AXI_LOCK, AXI_CACHE, AXI_PROT, AXI_QOS, AXI_AUSER};

    // W is never gated: AXI lets write data lead its AW
    assign dn.w_valid = up.w_valid;
    assign dn.w_data  = up.w_data;
    assign dn.w_strb  = up.w_strb;
    assign dn.w_last  = up.w_last;
    assign dn.w_user  = AXI_WUSER;
    assign up.w_ready = dn.w_ready;

    assign up.b_valid = dn.b_valid;
    assign up.b_id    = {{(UP_ID_W-DN_ID_W){1'b0}}, dn.b_id};
    assign up.b_resp  = dn.b_resp;
    assign dn.b_ready = up.b_ready;

    assign up.r_valid = dn.r_valid;
    assign up.r_id    = {{(UP_ID_W-DN_ID_W){1'b0}}, dn.r_id};
    assign up.r_data  = dn.r_data;
    assign up.r_resp  = dn.r_resp;
    assign up.r_last  = dn.r_last;
    assign dn.r_ready = up.r_ready;

    assign w_rd_dec = dn.r_valid && up.r_ready && dn.r_last;
    assign w_wr_dec = dn.b_valid && up.b_ready;

    // Counts update on the registered edge only, so a completion at the cap
    // reopens AR/AW one cycle later rather than through a comb path.
    always_ff @(posedge dla_core_clk) begin
        if (dla_reset) begin
            r_rd_ostd       <= '0;
            r_wr_ostd       <= '0;
            r_sts_id_trunc  <= 1'b0;
            r_sts_underflow <= 1'b0;
        end else begin
            r_rd_ostd <= ostd_next(r_rd_ostd, w_ar_acc, w_rd_dec);
            r_wr_ostd <= ostd_next(r_wr_ostd, w_aw_acc, w_wr_dec);
            if (w_ar_trunc || w_aw_trunc)
                r_sts_id_trunc <= 1'b1;
            if ((w_rd_dec && r_rd_ostd == '0) || (w_wr_dec && r_wr_ostd == '0))
                r_sts_underflow <= 1'b1;
        end
    end

    assign rd_ostd       = r_rd_ostd;
    assign wr_ostd       = r_wr_ostd;
    assign sts_id_trunc  = r_sts_id_trunc;
    assign sts_underflow = r_sts_underflow;

`ifdef NVDLA_DBB_RESP_ERR_CNT_EN
    logic [15:0] r_rresp_err_cnt, r_bresp_err_cnt;
    logic        w_r_err, w_b_err;

    assign w_r_err = dn.r_valid && up.r_ready && (dn.r_resp != RESP_OKAY);
    assign w_b_err = w_wr_dec && (dn.b_resp != RESP_OKAY);

    always_ff @(posedge dla_core_clk) begin
        if (dla_reset) begin
            r_rresp_err_cnt <= 16'h0;
            r_bresp_err_cnt <= 16'h0;
        end else begin
            if (w_r_err && r_rresp_err_cnt != 16'hFFFF)
                r_rresp_err_cnt <= r_rresp_err_cnt + 16'd1;
            if (w_b_err && r_bresp_err_cnt != 16'hFFFF)
                r_bresp_err_cnt <= r_bresp_err_cnt + 16'd1;
        end
    end

    assign rresp_err_cnt = r_rresp_err_cnt;
    assign bresp_err_cnt = r_bresp_err_cnt;
`else
    assign rresp_err_cnt = 16'h0;
    assign bresp_err_cnt = 16'h0;
`endif

    // Core-side sideband is replaced by fixed values toward the bus
    assign w_unused_ok = ^{up.ar_size, up.ar_burst, up.ar_lock, up.ar_cache, up.ar_prot, up.ar_qos, up.ar_user,
                           up.aw_size, up.aw_burst, up.aw_lock, up.aw_cache, up.aw_prot, up.aw_qos, up.aw_user,
                           up.w_user};
endmodule
